// File: rtl/bcd_counter_ndigit.sv
// Multi-digit BCD up/down counter with synchronous clear, validated load,
// and selectable wrap-around or saturating behaviour at the count bounds.
module bcd_counter_ndigit #(
    parameter int unsigned DIGITS   = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  enable,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  carry,
    output logic                  load_error,
    output logic                  at_max,
    output logic                  at_min
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] bcd_q, bcd_d;
    logic         carry_q, carry_d;
    logic         lerr_q, lerr_d;

    logic [W-1:0] stepped;
    logic         ripple_out;
    logic         load_valid;
    logic         all_nine;
    logic         all_zero;

    // Ripple one step through the digits; ripple_out set means the step crossed a bound.
    always_comb begin
        logic       prop;
        logic [3:0] nib;
        stepped = bcd_q;
        prop    = 1'b1;
        nib     = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = bcd_q[4*i +: 4];
            if (prop) begin
                if (up) begin
                    if (nib == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = nib + 4'd1;
                        prop              = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = nib - 4'd1;
                        prop              = 1'b0;
                    end
                end
            end
        end
        ripple_out = prop;
    end

    always_comb begin
        load_valid = 1'b1;
        all_nine   = 1'b1;
        all_zero   = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_value[4*i +: 4] > 4'd9) load_valid = 1'b0;
            if (bcd_q[4*i +: 4] != 4'd9)     all_nine   = 1'b0;
            if (bcd_q[4*i +: 4] != 4'd0)     all_zero   = 1'b0;
        end
    end

    // Command priority: clear, then load, then a count step.
    always_comb begin
        bcd_d   = bcd_q;
        carry_d = 1'b0;
        lerr_d  = 1'b0;
        if (clear) begin
            bcd_d = '0;
        end else if (load) begin
            if (load_valid) begin
                bcd_d = load_value;
            end else begin
                lerr_d = 1'b1;
            end
        end else if (enable) begin
            carry_d = ripple_out;
            if (!(ripple_out && SATURATE)) begin
                bcd_d = stepped;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q   <= '0;
            carry_q <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            lerr_q  <= lerr_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign carry      = carry_q;
    assign load_error = lerr_q;
    assign at_max     = all_nine;
    assign at_min     = all_zero;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed bench for bcd_counter_ndigit: a wrapping and a saturating instance
// share all inputs so both boundary modes are checked from one stimulus stream.
module tb_bcd_counter_ndigit;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        load;
    logic [11:0] load_value;
    logic        enable;
    logic        up;

    logic [11:0] u0_bcd, u1_bcd;
    logic        u0_carry, u1_carry;
    logic        u0_lerr, u1_lerr;
    logic        u0_max, u1_max;
    logic        u0_min, u1_min;

    int n_checks;
    int n_fail;

    bcd_counter_ndigit #(.DIGITS(3), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up(up), .bcd_out(u0_bcd), .carry(u0_carry),
        .load_error(u0_lerr), .at_max(u0_max), .at_min(u0_min)
    );

    bcd_counter_ndigit #(.DIGITS(3), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up(up), .bcd_out(u1_bcd), .carry(u1_carry),
        .load_error(u1_lerr), .at_max(u1_max), .at_min(u1_min)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] to_bcd(input int v);
        to_bcd = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0; load = 1'b0; enable = 1'b0; up = 1'b1; load_value = 12'h000;
    endtask

    task automatic do_load(input logic [11:0] v);
        idle();
        load = 1'b1; load_value = v;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #2;
        n_checks++; if (u0_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h expected 000", u0_bcd); end
        n_checks++; if ({u0_carry, u0_lerr, u1_carry, u1_lerr} !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {u0_carry, u0_lerr, u1_carry, u1_lerr}); end
        n_checks++; if ({u0_min, u0_max} !== 2'b10) begin n_fail++; $display("FAIL reset_flags: min/max got %b expected 10", {u0_min, u0_max}); end
        @(negedge clk);
        reset = 1'b0;
        load = 1'b1; load_value = 12'h321;
        tick();
        idle();
        n_checks++; if (u0_bcd !== 12'h321) begin n_fail++; $display("FAIL first_cmd_after_reset: got %h expected 321", u0_bcd); end
    endtask

    task automatic test_count_1000();
        int exp_v;
        idle();
        clear = 1'b1;
        tick();
        n_checks++; if (u0_bcd !== 12'h000 || u0_carry !== 1'b0) begin n_fail++; $display("FAIL clear: got %h/%b expected 000/0", u0_bcd, u0_carry); end
        exp_v = 0;
        idle();
        enable = 1'b1; up = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            exp_v = (exp_v + 1) % 1000;
            n_checks++; if (u0_bcd !== to_bcd(exp_v)) begin n_fail++; $display("FAIL count_bcd step %0d: got %h expected %h", i, u0_bcd, to_bcd(exp_v)); end
            n_checks++; if (u0_carry !== (exp_v == 0)) begin n_fail++; $display("FAIL count_carry step %0d: got %b expected %b", i, u0_carry, exp_v == 0); end
        end
        n_checks++; if (u1_bcd !== 12'h999 || u1_carry !== 1'b1) begin n_fail++; $display("FAIL sat_overflow: got %h/%b expected 999/1", u1_bcd, u1_carry); end
        n_checks++; if (u1_max !== 1'b1) begin n_fail++; $display("FAIL sat_at_max: got %b expected 1", u1_max); end
        idle();
        tick();
        n_checks++; if (u0_carry !== 1'b0 || u1_carry !== 1'b0) begin n_fail++; $display("FAIL idle_carry: got %b%b expected 00", u0_carry, u1_carry); end
        n_checks++; if (u0_bcd !== 12'h000 || u1_bcd !== 12'h999) begin n_fail++; $display("FAIL idle_hold: got %h/%h expected 000/999", u0_bcd, u1_bcd); end
    endtask

    task automatic test_ripple();
        do_load(12'h099);
        n_checks++; if (u0_bcd !== 12'h099 || u0_carry !== 1'b0) begin n_fail++; $display("FAIL load_099: got %h/%b expected 099/0", u0_bcd, u0_carry); end
        enable = 1'b1; up = 1'b1;
        tick();
        n_checks++; if (u0_bcd !== 12'h100 || u0_carry !== 1'b0) begin n_fail++; $display("FAIL ripple_inc: got %h/%b expected 100/0", u0_bcd, u0_carry); end
        up = 1'b0;
        tick();
        n_checks++; if (u0_bcd !== 12'h099 || u1_bcd !== 12'h099) begin n_fail++; $display("FAIL ripple_dec: got %h/%h expected 099/099", u0_bcd, u1_bcd); end
        idle();
    endtask

    task automatic test_underflow();
        do_load(12'h000);
        enable = 1'b1; up = 1'b0;
        tick();
        n_checks++; if (u0_bcd !== 12'h999 || u0_carry !== 1'b1) begin n_fail++; $display("FAIL wrap_underflow: got %h/%b expected 999/1", u0_bcd, u0_carry); end
        n_checks++; if (u1_bcd !== 12'h000 || u1_carry !== 1'b1) begin n_fail++; $display("FAIL sat_underflow: got %h/%b expected 000/1", u1_bcd, u1_carry); end
        tick();
        n_checks++; if (u0_bcd !== 12'h998 || u0_carry !== 1'b0) begin n_fail++; $display("FAIL wrap_after: got %h/%b expected 998/0", u0_bcd, u0_carry); end
        n_checks++; if (u1_bcd !== 12'h000 || u1_carry !== 1'b1) begin n_fail++; $display("FAIL sat_hold_carry: got %h/%b expected 000/1", u1_bcd, u1_carry); end
        idle();
        tick();
        n_checks++; if (u0_carry !== 1'b0 || u1_carry !== 1'b0) begin n_fail++; $display("FAIL carry_drop: got %b%b expected 00", u0_carry, u1_carry); end
    endtask

    task automatic test_load_error();
        do_load(12'h456);
        load = 1'b1; load_value = 12'h4A6;
        tick();
        n_checks++; if (u0_bcd !== 12'h456 || u0_lerr !== 1'b1) begin n_fail++; $display("FAIL bad_load: got %h/%b expected 456/1", u0_bcd, u0_lerr); end
        idle();
        tick();
        n_checks++; if (u0_bcd !== 12'h456 || u0_lerr !== 1'b0) begin n_fail++; $display("FAIL lerr_one_cycle: got %h/%b expected 456/0", u0_bcd, u0_lerr); end
        load = 1'b1; load_value = 12'hF12;
        tick();
        n_checks++; if (u1_bcd !== 12'h456 || u1_lerr !== 1'b1) begin n_fail++; $display("FAIL bad_top_nibble: got %h/%b expected 456/1", u1_bcd, u1_lerr); end
        load = 1'b1; load_value = 12'h789; enable = 1'b1; up = 1'b1;
        tick();
        n_checks++; if (u0_bcd !== 12'h789 || u0_lerr !== 1'b0 || u0_carry !== 1'b0) begin n_fail++; $display("FAIL load_beats_enable: got %h/%b/%b expected 789/0/0", u0_bcd, u0_lerr, u0_carry); end
        idle();
    endtask

    task automatic test_priority();
        do_load(12'h123);
        clear = 1'b1; load = 1'b1; load_value = 12'h456; enable = 1'b1; up = 1'b1;
        tick();
        n_checks++; if (u0_bcd !== 12'h000 || u0_carry !== 1'b0 || u0_lerr !== 1'b0) begin n_fail++; $display("FAIL clear_priority: got %h/%b/%b expected 000/0/0", u0_bcd, u0_carry, u0_lerr); end
        do_load(12'h555);
        clear = 1'b1; load = 1'b1; load_value = 12'hABC;
        tick();
        n_checks++; if (u0_bcd !== 12'h000 || u0_lerr !== 1'b0) begin n_fail++; $display("FAIL clear_over_bad_load: got %h/%b expected 000/0", u0_bcd, u0_lerr); end
        idle();
    endtask

    task automatic test_async_reset();
        do_load(12'h998);
        enable = 1'b1; up = 1'b1;
        #3 reset = 1'b1;
        #1;
        n_checks++; if (u0_bcd !== 12'h000 || u0_carry !== 1'b0 || u0_lerr !== 1'b0) begin n_fail++; $display("FAIL async_reset: got %h/%b/%b expected 000/0/0", u0_bcd, u0_carry, u0_lerr); end
        n_checks++; if (u0_min !== 1'b1 || u1_min !== 1'b1) begin n_fail++; $display("FAIL async_at_min: got %b%b expected 11", u0_min, u1_min); end
        #2 reset = 1'b0;
        tick();
        n_checks++; if (u0_bcd !== 12'h001 || u0_carry !== 1'b0) begin n_fail++; $display("FAIL count_after_reset: got %h/%b expected 001/0", u0_bcd, u0_carry); end
        idle();
        load = 1'b1; load_value = 12'h4A6;
        #3 reset = 1'b1;
        load = 1'b0;
        #2 reset = 1'b0;
        tick();
        n_checks++; if (u0_lerr !== 1'b0 || u0_bcd !== 12'h000) begin n_fail++; $display("FAIL load_cancelled: got %h/%b expected 000/0", u0_bcd, u0_lerr); end
        idle();
    endtask

    task automatic test_back_to_back();
        do_load(12'h010);
        enable = 1'b1; up = 1'b0;
        tick();
        n_checks++; if (u0_bcd !== 12'h009) begin n_fail++; $display("FAIL b2b_dec: got %h expected 009", u0_bcd); end
        up = 1'b1;
        tick();
        n_checks++; if (u0_bcd !== 12'h010) begin n_fail++; $display("FAIL b2b_inc: got %h expected 010", u0_bcd); end
        tick();
        n_checks++; if (u0_bcd !== 12'h011) begin n_fail++; $display("FAIL b2b_inc2: got %h expected 011", u0_bcd); end
        load = 1'b1; load_value = 12'h999;
        tick();
        n_checks++; if (u0_bcd !== 12'h999 || u0_max !== 1'b1 || u0_min !== 1'b0) begin n_fail++; $display("FAIL b2b_load_max: got %h/%b/%b expected 999/1/0", u0_bcd, u0_max, u0_min); end
        load = 1'b0;
        tick();
        n_checks++; if (u0_bcd !== 12'h000 || u0_carry !== 1'b1 || u1_bcd !== 12'h999) begin n_fail++; $display("FAIL b2b_overflow: got %h/%b/%h expected 000/1/999", u0_bcd, u0_carry, u1_bcd); end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        test_reset();
        test_count_1000();
        test_ripple();
        test_underflow();
        test_load_error();
        test_priority();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_ndigit.md
BCD_COUNTER_NDIGIT -- requirements
Module: bcd_counter_ndigit

Interface
REQ-001: Parameter DIGITS, default 3, SHALL set the number of BCD digits (legal range 1..8); count width W = 4*DIGITS.
REQ-002: Parameter SATURATE, default 0, SHALL select the boundary mode: 0 = wrap-around, 1 = hold at bound.
REQ-003: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: clear  input  1  synchronous clear of the count.
REQ-006: load  input  1  load load_value this cycle.
REQ-007: load_value  input  W  BCD value to load; digit i is at bits [4i+3:4i], with digit 0 least significant.
REQ-008: enable  input  1  perform one count step this cycle.
REQ-009: up  input  1  step direction: 1 = increment, 0 = decrement.
REQ-010: bcd_out  output  W  registered BCD count.
REQ-011: carry  output  1  registered one-cycle pulse on a boundary event (overflow or underflow).
REQ-012: load_error  output  1  registered one-cycle pulse on a rejected load.
REQ-013: at_max  output  1  combinational; high when every digit of bcd_out is 9.
REQ-014: at_min  output  1  combinational; high when every digit of bcd_out is 0.

Function
REQ-015: Command priority SHALL be clear > load > enable; lower-priority commands in the same cycle SHALL be ignored.
REQ-016: Every command SHALL take effect on bcd_out at the first rising edge after it is sampled (latency 1); with no command, bcd_out SHALL hold.
REQ-017: clear SHALL set bcd_out to all zeros, and carry and load_error SHALL be 0 in the following cycle.
REQ-018: load with every nibble of load_value <= 9 SHALL copy load_value to bcd_out and leave carry at 0.
REQ-019: load with any nibble of load_value > 9 SHALL leave bcd_out unchanged and pulse load_error high for exactly one cycle.
REQ-020: Increment SHALL add 1 to digit 0.
REQ-021: During increment, a digit at 9 SHALL become 0 and propagate the increment to the next digit in the same cycle; propagation SHALL stop at the first digit below 9.
REQ-022: Decrement SHALL subtract 1 from digit 0.
REQ-023: During decrement, a digit at 0 SHALL become 9 and propagate the borrow to the next digit in the same cycle; propagation SHALL stop at the first digit above 0.
REQ-024: Increment from all-9s with SATURATE=0 SHALL give all-0s and pulse carry for one cycle.
REQ-025: Increment from all-9s with SATURATE=1 SHALL hold all-9s and pulse carry.
REQ-026: Decrement from all-0s with SATURATE=0 SHALL give all-9s and pulse carry for one cycle.
REQ-027: Decrement from all-0s with SATURATE=1 SHALL hold all-0s and pulse carry.
REQ-028: carry SHALL be 0 in every cycle after a non-boundary step, load, clear or idle cycle.
REQ-029: When enable stays asserted at a bound, carry SHALL pulse once per attempted step; in saturate mode this means carry stays high continuously.
REQ-030: A direction change between cycles SHALL take effect on the next step with no extra latency.
REQ-031: The count register SHALL never hold a nibble > 9, whatever the input sequence.

Reset
REQ-032: Asserting reset SHALL immediately force bcd_out = 0, carry = 0 and load_error = 0, independent of clk.
REQ-033: Reset asserted mid-count or mid-load SHALL cancel the in-flight operation, with no residual pulse after release.
REQ-034: After reset is released, the first command SHALL be honoured at the first rising edge on which it is sampled.

Verification (DIGITS=3 unless stated)
REQ-035: Reset, then enable=1, up=1 for 1000 cycles, SATURATE=0 -> bcd_out steps 000..999,000; carry is high only in the cycle bcd_out = 000 after 999.
REQ-036: load 0x099, then one increment -> bcd_out = 0x100, carry = 0; then one decrement -> 0x099.
REQ-037: SATURATE=0, load 0x000, decrement -> bcd_out = 0x999, carry pulses one cycle; SATURATE=1, same stimulus -> bcd_out = 0x000, carry = 1.
REQ-038: bcd_out = 0x456, load 0x4A6 -> bcd_out stays 0x456, load_error pulses one cycle; load and enable together with a valid value -> load wins.
REQ-039: clear, load and enable asserted in the same cycle with bcd_out = 0x123 -> bcd_out = 0x000.
REQ-040: Async reset pulsed between clock edges while counting at 0x998 -> outputs are 0 before the next edge; at_min = 1.
